// File: rtl/breath_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : breath_key_ctrl
// Brief    : Debounced key front-end for the breath LED: a short press toggles
//            breath_en, a long press steps speed_sel. Define
//            BREATH_KEY_AUTOREPEAT_EN to repeat the long event while held.
// Revision : 1.0 - initial release
// ============================================================================
module breath_key_ctrl #(
    parameter logic [19:0] CNT_DEBOUNCE_MAX = 20'd999_999,
    parameter logic [5:0]  CNT_LONG_MAX     = 6'd49
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_in,
    output logic       breath_en,
    output logic [1:0] speed_sel,
    output logic       key_flag,
    output logic       long_flag
);

    localparam logic [1:0] c_idle        = 2'd0;
    localparam logic [1:0] c_filter_down = 2'd1;
    localparam logic [1:0] c_pressed     = 2'd2;
    localparam logic [1:0] c_filter_up   = 2'd3;

    logic        r_key_meta;
    logic        r_key_s;
    logic [1:0]  r_state;
    logic [19:0] r_cnt_db;
    logic [5:0]  r_hold_cnt;
    logic        r_long_done;
    logic        w_db_done;
    logic        w_long_event;

    // Synchronizer idles high so a reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_key_meta <= key_in;
            r_key_s    <= r_key_meta;
        end
    end

    assign w_db_done = (r_cnt_db == CNT_DEBOUNCE_MAX);

`ifdef BREATH_KEY_AUTOREPEAT_EN
    assign w_long_event = (r_state == c_pressed) && w_db_done &&
                          (r_hold_cnt == CNT_LONG_MAX);
`else
    assign w_long_event = (r_state == c_pressed) && w_db_done &&
                          (r_hold_cnt == CNT_LONG_MAX) && !r_long_done;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= c_idle;
            r_cnt_db    <= 20'd0;
            r_hold_cnt  <= 6'd0;
            r_long_done <= 1'b0;
            breath_en   <= 1'b1;
            speed_sel   <= 2'd0;
            key_flag    <= 1'b0;
            long_flag   <= 1'b0;
        end else begin
            key_flag  <= 1'b0;
            long_flag <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_cnt_db <= 20'd0;
                    if (!r_key_s) begin
                        r_state <= c_filter_down;
                    end
                end
                c_filter_down: begin
                    if (r_key_s) begin
                        r_state  <= c_idle;
                        r_cnt_db <= 20'd0;
                    end else if (w_db_done) begin
                        r_state     <= c_pressed;
                        r_cnt_db    <= 20'd0;
                        r_hold_cnt  <= 6'd0;
                        r_long_done <= 1'b0;
                        key_flag    <= 1'b1;
                    end else begin
                        r_cnt_db <= r_cnt_db + 20'd1;
                    end
                end
                c_pressed: begin
                    // The long event fires even if release is seen in the same cycle.
                    if (w_long_event) begin
                        speed_sel   <= speed_sel + 2'd1;
                        long_flag   <= 1'b1;
                        r_long_done <= 1'b1;
                    end
                    if (r_key_s) begin
                        r_state  <= c_filter_up;
                        r_cnt_db <= 20'd0;
                    end else if (w_db_done) begin
                        r_cnt_db <= 20'd0;
`ifdef BREATH_KEY_AUTOREPEAT_EN
                        if (w_long_event) begin
                            r_hold_cnt <= 6'd0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 6'd1;
                        end
`else
                        if (r_hold_cnt != CNT_LONG_MAX) begin
                            r_hold_cnt <= r_hold_cnt + 6'd1;
                        end
`endif
                    end else begin
                        r_cnt_db <= r_cnt_db + 20'd1;
                    end
                end
                c_filter_up: begin
                    if (!r_key_s) begin
                        r_state  <= c_pressed;
                        r_cnt_db <= 20'd0;
                    end else if (w_db_done) begin
                        r_state  <= c_idle;
                        r_cnt_db <= 20'd0;
                        if (!r_long_done) begin
                            breath_en <= ~breath_en;
                        end
                    end else begin
                        r_cnt_db <= r_cnt_db + 20'd1;
                    end
                end
                default: begin
                    r_state  <= c_idle;
                    r_cnt_db <= 20'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_breath_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_breath_key_ctrl
// Brief    : Self-checking bench for breath_key_ctrl (window 10, long 5 windows).
// Revision : 1.0 - initial release
// ============================================================================
module tb_breath_key_ctrl;

    localparam int DB = 10;   // clocks per debounce window
    localparam int LW = 5;    // windows per long event
`ifdef BREATH_KEY_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_in    = 1'b1;
    logic       breath_en;
    logic [1:0] speed_sel;
    logic       key_flag;
    logic       long_flag;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    bit check_en    = 1'b0;
    int kf_q[$];
    int lf_q[$];

    breath_key_ctrl #(
        .CNT_DEBOUNCE_MAX(20'd9),
        .CNT_LONG_MAX    (6'd4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_in   (key_in),
        .breath_en(breath_en),
        .speed_sel(speed_sel),
        .key_flag (key_flag),
        .long_flag(long_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: run lengths of the synchronized key plus total held clocks.
    typedef struct {
        logic       s1;
        logic       s2;
        bit         pressed;
        int         run;
        int         rel;
        int         held;
        bit         long_done;
        logic       breath;
        logic [1:0] speed;
        logic       kf;
        logic       lf;
    } model_t;

    localparam model_t M_RESET = '{s1: 1'b1, s2: 1'b1, pressed: 1'b0, run: 0,
                                   rel: 0, held: 0, long_done: 1'b0, breath: 1'b1,
                                   speed: 2'd0, kf: 1'b0, lf: 1'b0};

    model_t m = M_RESET;

    function automatic model_t step(input model_t s, input logic kin);
        model_t n;
        logic   ks;
        int     cand;
        bit     ev;
        n    = s;
        ks   = s.s2;
        n.s2 = s.s1;
        n.s1 = kin;
        n.kf = 1'b0;
        n.lf = 1'b0;
        if (!s.pressed) begin
            n.run = ks ? 0 : s.run + 1;
            if (n.run == DB + 1) begin
                n.pressed   = 1'b1;
                n.kf        = 1'b1;
                n.run       = 0;
                n.rel       = 0;
                n.held      = 0;
                n.long_done = 1'b0;
            end
        end else if (s.rel > 0) begin
            if (ks) begin
                n.rel = s.rel + 1;
                if (n.rel == DB + 1) begin
                    n.pressed = 1'b0;
                    n.rel     = 0;
                    if (!s.long_done) n.breath = ~s.breath;
                end
            end else begin
                n.rel  = 0;
                n.held = (s.held / DB) * DB;
            end
        end else begin
            cand = s.held + 1;
            ev   = (cand == DB * LW) && (AUTOREP || !s.long_done);
            if (ev) begin
                n.speed     = s.speed + 2'd1;
                n.lf        = 1'b1;
                n.long_done = 1'b1;
            end
            if (ks) begin
                n.rel  = 1;
                n.held = (s.held / DB) * DB;
            end else begin
                n.held = (ev && AUTOREP) ? 0 : cand;
            end
        end
        return n;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m <= M_RESET;
        else            m <= step(m, key_in);
    end

    always @(negedge sys_clk) begin
        if (check_en) begin
            vectors++;
            if ({breath_en, speed_sel, key_flag, long_flag} !== {m.breath, m.speed, m.kf, m.lf}) begin
                miscompares++;
                $display("FAIL model t=%0t: dut be=%b sp=%0d kf=%b lf=%b, model be=%b sp=%0d kf=%b lf=%b",
                         $time, breath_en, speed_sel, key_flag, long_flag,
                         m.breath, m.speed, m.kf, m.lf);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " breath_en"}, int'(breath_en), 1);
        check({tag, " speed_sel"}, int'(speed_sel), 0);
        check({tag, " key_flag"},  int'(key_flag),  0);
        check({tag, " long_flag"}, int'(long_flag), 0);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (key_flag)  kf_q.push_back(cyc);
        if (long_flag) lf_q.push_back(cyc);
    endtask

    task automatic hold_key(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) tick();
    endtask

    task automatic start_seq();
        kf_q.delete();
        lf_q.delete();
        t0 = cyc;
    endtask

    task automatic pulse_reset();
        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        // Power-on reset
        repeat (3) tick();
        check_reset_outputs("por");
        sys_rst_n = 1'b1;
        check_en  = 1'b1;
        repeat (3) tick();

        // Short press: flag 12 clocks after the first sample of the low key
        start_seq();
        hold_key(1'b0, 30);
        check("short kf count", kf_q.size(), 1);
        check("short kf latency", (kf_q.size() > 0) ? kf_q[0] - t0 : -1, 13);
        hold_key(1'b1, 12);
        check("short breath before toggle", int'(breath_en), 1);
        hold_key(1'b1, 1);
        check("short breath after toggle", int'(breath_en), 0);
        hold_key(1'b1, 17);
        check("short no lf", lf_q.size(), 0);

        // 5-clock glitch
        start_seq();
        hold_key(1'b0, 5);
        hold_key(1'b1, 30);
        check("glitch kf count", kf_q.size(), 0);
        check("glitch breath", int'(breath_en), 0);
        check("glitch speed", int'(speed_sel), 0);

        // Long press, 60 clocks
        start_seq();
        hold_key(1'b0, 60);
        hold_key(1'b1, 30);
        check("long kf count", kf_q.size(), 1);
        check("long lf count", lf_q.size(), 1);
        check("long lf latency", (lf_q.size() > 0) ? lf_q[0] - t0 : -1, 63);
        check("long speed", int'(speed_sel), 1);
        check("long breath unchanged", int'(breath_en), 0);

        // Four long presses wrap speed_sel 1,2,3,0
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            hold_key(1'b0, 60);
            hold_key(1'b1, 30);
            check($sformatf("wrap speed %0d", k), int'(speed_sel), (k + 1) % 4);
        end
        check("wrap breath", int'(breath_en), 1);

        // 120-clock hold
        pulse_reset();
        start_seq();
        hold_key(1'b0, 120);
        hold_key(1'b1, 30);
        check("hold lf first", (lf_q.size() > 0) ? lf_q[0] - t0 : -1, 63);
        check("hold breath", int'(breath_en), 1);
`ifdef BREATH_KEY_AUTOREPEAT_EN
        check("hold lf count", lf_q.size(), 2);
        check("hold lf spacing", (lf_q.size() > 1) ? lf_q[1] - lf_q[0] : -1, 50);
        check("hold speed", int'(speed_sel), 2);
`else
        check("hold lf count", lf_q.size(), 1);
        check("hold speed", int'(speed_sel), 1);
`endif

        // Reset 20 clocks into PRESSED
        hold_key(1'b0, 30);
        hold_key(1'b1, 30);
        check("pre-reset breath", int'(breath_en), 0);
        start_seq();
        hold_key(1'b0, 33);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-press reset");
        repeat (3) tick();
        sys_rst_n = 1'b1;
        start_seq();
        hold_key(1'b0, 5);
        hold_key(1'b1, 40);
        check("post-reset kf", kf_q.size(), 0);
        check("post-reset lf", lf_q.size(), 0);
        check("post-reset breath", int'(breath_en), 1);
        check("post-reset speed", int'(speed_sel), 0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
